// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler sharing one signed/unsigned N-bit multiplier between N_REQ requesters.
// Two-stage pipeline: S1 holds operands, S2 holds the registered product returned on the result port.
module mul_rr_scheduler #(
  parameter int N     = 8,
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*N-1:0] req_a,
  input  logic [N_REQ*N-1:0] req_b,
  input  logic [N_REQ-1:0]   req_signed,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*N-1:0]     res_data,
  output logic [IDW-1:0]     res_id,
  output logic               res_signed,
  output logic               busy
);

  logic           v1_q, v1_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           sgn1_q, sgn1_d;
  logic [IDW-1:0] id1_q, id1_d;

  logic           v2_q, v2_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic           sgn2_q, sgn2_d;
  logic [IDW-1:0] id2_q, id2_d;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic           s1_adv, s2_adv;
  logic           grant_any, accept;
  logic [IDW-1:0] grant_id;
  int             grant_idx;

  logic signed [N:0]     a_ext, b_ext;
  logic signed [2*N+1:0] prod_full;

  assign s2_adv = !v2_q || res_ready;
  assign s1_adv = !v1_q || s2_adv;

  // Search downward so the entry closest to rr_ptr is the last one written and wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    grant_id = IDW'(grant_idx);
  end

  // Gating with rst_n keeps ready low for the whole time reset is held.
  assign accept = rst_n && s1_adv && grant_any;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // One extra sign/zero bit per operand makes a single signed multiply cover both modes.
  assign a_ext     = {sgn1_q & a_q[N-1], a_q};
  assign b_ext     = {sgn1_q & b_q[N-1], b_q};
  assign prod_full = a_ext * b_ext;

  always_comb begin
    v1_d     = v1_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn1_d   = sgn1_q;
    id1_d    = id1_q;
    v2_d     = v2_q;
    prod_d   = prod_q;
    sgn2_d   = sgn2_q;
    id2_d    = id2_q;
    rr_ptr_d = rr_ptr_q;

    if (s2_adv) begin
      v2_d = v1_q;
      if (v1_q) begin
        prod_d = prod_full[2*N-1:0];
        sgn2_d = sgn1_q;
        id2_d  = id1_q;
      end
    end

    if (s1_adv) begin
      v1_d = accept;
      if (accept) begin
        a_d    = req_a[grant_idx*N +: N];
        b_d    = req_b[grant_idx*N +: N];
        sgn1_d = req_signed[grant_idx];
        id1_d  = grant_id;
        if (grant_id == IDW'(N_REQ - 1)) rr_ptr_d = '0;
        else                             rr_ptr_d = grant_id + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sgn1_q   <= 1'b0;
      id1_q    <= '0;
      v2_q     <= 1'b0;
      prod_q   <= '0;
      sgn2_q   <= 1'b0;
      id2_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      v1_q     <= v1_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn1_q   <= sgn1_d;
      id1_q    <= id1_d;
      v2_q     <= v2_d;
      prod_q   <= prod_d;
      sgn2_q   <= sgn2_d;
      id2_q    <= id2_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign res_valid  = v2_q;
  assign res_data   = prod_q;
  assign res_id     = id2_q;
  assign res_signed = sgn2_q;
  assign busy       = v1_q || v2_q;

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Directed self-checking bench for mul_rr_scheduler (N=8, N_REQ=4).
// Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
module tb_mul_rr_scheduler;

  localparam int N     = 8;
  localparam int N_REQ = 4;
  localparam int IDW   = 2;

  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*N-1:0] req_a;
  logic [N_REQ*N-1:0] req_b;
  logic [N_REQ-1:0]   req_signed;
  logic               res_valid;
  logic               res_ready;
  logic [2*N-1:0]     res_data;
  logic [IDW-1:0]     res_id;
  logic               res_signed;
  logic               busy;

  int checkCount;
  int errorCount;

  mul_rr_scheduler #(.N(N), .N_REQ(N_REQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_signed (res_signed),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic [N_REQ*N-1:0] a,
                               input logic [N_REQ*N-1:0] b, input logic [N_REQ-1:0] sgn);
    req_valid  = valid;
    req_a      = a;
    req_b      = b;
    req_signed = sgn;
  endtask

  task automatic driveEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    driveEdge();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // One isolated request from requester id; result expected two edges after acceptance.
  task automatic singleRequest(input string tag, input int id, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic sgn, input logic [15:0] expected);
    logic [N_REQ*N-1:0] av, bv;
    logic [N_REQ-1:0]   vv, sv;
    av = '0; bv = '0; vv = '0; sv = '0;
    av[id*N +: N] = a;
    bv[id*N +: N] = b;
    vv[id] = 1'b1;
    sv[id] = sgn;
    driveEdge();
    applyStimulus(vv, av, bv, sv);
    @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(vv));
    driveEdge();
    applyStimulus('0, av, bv, sv);
    @(negedge clk);
    checkOutput({tag, "_s1_only"}, {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    checkOutput({tag, "_data"}, 32'(res_data), 32'(expected));
    checkOutput({tag, "_id"}, 32'(res_id), 32'(id));
    checkOutput({tag, "_signed"}, {31'd0, res_signed}, {31'd0, sgn});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] fairData [4];
    logic [15:0] bpData   [4];
    checkCount = 0;
    errorCount = 0;
    fairData = '{16'h000A, 16'hFFFA, 16'h002C, 16'hFFB0};
    bpData   = '{16'd10, 16'd22, 16'd36, 16'd52};

    // Reset state, with requests pending to show ready stays low during reset
    rst_n     = 1'b0;
    res_ready = 1'b1;
    applyStimulus(4'hF, '0, '0, '0);
    #12;
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'd0);
    checkOutput("rst_res_id", 32'(res_id), 32'd0);
    checkOutput("rst_res_signed", {31'd0, res_signed}, 32'd0);
    applyStimulus('0, '0, '0, '0);
    #2;
    rst_n = 1'b1;

    // Signedness and extreme operands
    singleRequest("s_fd05", 0, 8'hFD, 8'h05, 1'b1, 16'hFFF1);
    singleRequest("u_fd05", 2, 8'hFD, 8'h05, 1'b0, 16'h04F1);
    singleRequest("s_ffff", 1, 8'hFF, 8'hFF, 1'b1, 16'h0001);
    singleRequest("u_ffff", 3, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    singleRequest("s_8080", 0, 8'h80, 8'h80, 1'b1, 16'h4000);
    singleRequest("u_8080", 2, 8'h80, 8'h80, 1'b0, 16'h4000);

    // Fairness: all requesters valid, one grant per clock in rotation
    pulseReset();
    applyStimulus(4'hF, {8'h05, 8'h04, 8'h03, 8'h02}, {8'hF0, 8'h0B, 8'hFE, 8'h05}, 4'b1010);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("fair_ready_%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 2) begin
        checkOutput($sformatf("fair_valid_%0d", k), {31'd0, res_valid}, 32'd1);
        checkOutput($sformatf("fair_id_%0d", k), 32'(res_id), 32'((k - 2) % 4));
        checkOutput($sformatf("fair_data_%0d", k), 32'(res_data), 32'(fairData[(k - 2) % 4]));
      end
      driveEdge();
    end
    applyStimulus('0, '0, '0, '0);
    repeat (3) driveEdge();

    // Backpressure: stream from req1, res_ready low for 5 cycles
    applyStimulus(4'b0010, {8'd0, 8'd0, 8'd1, 8'd0}, {8'd0, 8'd0, 8'd10, 8'd0}, 4'b0000);
    @(negedge clk);
    checkOutput("bp_ready_0", 32'(req_ready), 32'b0010);
    driveEdge();
    applyStimulus(4'b0010, {8'd0, 8'd0, 8'd2, 8'd0}, {8'd0, 8'd0, 8'd11, 8'd0}, 4'b0000);
    res_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_ready_1", 32'(req_ready), 32'b0010);
    driveEdge();
    applyStimulus(4'b0010, {8'd0, 8'd0, 8'd3, 8'd0}, {8'd0, 8'd0, 8'd12, 8'd0}, 4'b0000);
    for (int k = 2; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'd0);
      checkOutput($sformatf("bp_hold_data_%0d", k), 32'(res_data), 32'd10);
      checkOutput($sformatf("bp_hold_id_%0d", k), 32'(res_id), 32'd1);
      checkOutput($sformatf("bp_hold_valid_%0d", k), {31'd0, res_valid}, 32'd1);
      driveEdge();
    end
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_drain_valid_%0d", k), {31'd0, res_valid}, 32'd1);
      checkOutput($sformatf("bp_drain_data_%0d", k), 32'(res_data), 32'(bpData[k]));
      driveEdge();
      if (k == 0) applyStimulus(4'b0010, {8'd0, 8'd0, 8'd4, 8'd0}, {8'd0, 8'd0, 8'd13, 8'd0}, 4'b0000);
      if (k == 1) applyStimulus('0, '0, '0, '0);
    end
    @(negedge clk);
    checkOutput("bp_empty_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("bp_empty_busy", {31'd0, busy}, 32'd0);

    // Pointer skip/wrap with only req1 and req3 valid
    pulseReset();
    applyStimulus(4'b1010, {8'd7, 8'd0, 8'd6, 8'd0}, {8'd3, 8'd0, 8'd2, 8'd0}, 4'b0000);
    @(negedge clk);
    checkOutput("wrap_ready_0", 32'(req_ready), 32'b0010);
    driveEdge();
    @(negedge clk);
    checkOutput("wrap_ready_1", 32'(req_ready), 32'b1000);
    driveEdge();
    @(negedge clk);
    checkOutput("wrap_ready_2", 32'(req_ready), 32'b0010);
    checkOutput("wrap_res_id_2", 32'(res_id), 32'd1);
    checkOutput("wrap_res_data_2", 32'(res_data), 32'd12);
    driveEdge();
    @(negedge clk);
    checkOutput("wrap_res_id_3", 32'(res_id), 32'd3);
    checkOutput("wrap_res_data_3", 32'(res_data), 32'd21);
    applyStimulus(4'b0100, {8'd0, 8'd9, 8'd0, 8'd0}, {8'd0, 8'd9, 8'd0, 8'd0}, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      driveEdge();
      @(negedge clk);
      checkOutput($sformatf("lone2_ready_%0d", k), 32'(req_ready), 32'b0100);
    end
    @(negedge clk);
    checkOutput("lone2_res_data", 32'(res_data), 32'd81);
    checkOutput("lone2_res_id", 32'(res_id), 32'd2);

    // Reset with both stages full discards everything and returns the pointer to 0
    driveEdge();
    res_ready = 1'b0;
    applyStimulus(4'hF, {8'd5, 8'd4, 8'd3, 8'd2}, {8'd5, 8'd4, 8'd3, 8'd2}, 4'b0000);
    repeat (3) driveEdge();
    @(negedge clk);
    checkOutput("mid_full_busy", {31'd0, busy}, 32'd1);
    checkOutput("mid_full_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("mid_full_ready", 32'(req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
    driveEdge();
    rst_n = 1'b1;
    res_ready = 1'b1;
    applyStimulus(4'b1001, '0, '0, '0);
    @(negedge clk);
    checkOutput("post_rst_grant", 32'(req_ready), 32'b0001);
    driveEdge();
    applyStimulus('0, '0, '0, '0);
    repeat (3) driveEdge();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mul_rr_scheduler.md
# mul_rr_scheduler

Round-robin scheduler that shares one signed/unsigned N-bit multiplier between N_REQ requesters. Each requester offers operand pairs through a valid/ready handshake with a per-request signedness bit. The block arbitrates, pushes the winner through a 2-stage pipeline (operand register, product register) and returns the 2N-bit product tagged with the requester id on a single valid/ready result port. It sits between several arithmetic clients and the shared multiplier datapath.

## Interface
- `N`, 8, operand width in bits; product width is 2*N
- `N_REQ`, 4, number of requesters (≥2); `IDW = $clog2(N_REQ)`
- `clk` in 1, single clock, all state on rising edge
- `rst_n` in 1, reset, asynchronous and active-low
- `req_valid` in N_REQ, per-requester request valid
- `req_ready` out N_REQ, per-requester accept; at most one bit high
- `req_a` in N_REQ*N, operand a of requester i at `[i*N +: N]`
- `req_b` in N_REQ*N, operand b of requester i at `[i*N +: N]`
- `req_signed` in N_REQ, 1 = two's-complement multiply, 0 = unsigned
- `res_valid` out 1, result valid
- `res_ready` in 1, result consumer accept
- `res_data` out 2*N, product
- `res_id` out IDW, index of requester that issued the product
- `res_signed` out 1, signedness used for this product
- `busy` out 1, high while either pipeline stage holds a transaction

## Operation
- Arithmetic: signed mode computes the full 2N-bit two's-complement product of `$signed(a)*$signed(b)`; unsigned mode computes the zero-extended product of `a*b`. No truncation or overflow possible.
- Stage 1 (S1) holds {a, b, signed, id, v1}; stage 2 (S2) holds {product, signed, id, v2}; `res_*` are driven directly from S2, with `res_valid = v2`.
- `s2_adv = !v2 || res_ready`; `s1_adv = !v1 || s2_adv` (S1 can accept).
- Arbitration: when `s1_adv`, grant the first i with `req_valid[i]`, searching from `rr_ptr` upward modulo N_REQ; assert `req_ready[i]` only for that i. When `!s1_adv`, all `req_ready` are 0.
- `req_ready` may depend combinationally on `req_valid` and `res_ready`. Requesters must not make `req_valid` depend on `req_ready`, and must hold operands stable while valid and not accepted.
- On accept from i: S1 loads the operands, `req_signed[i]` and id i; `rr_ptr <= (i+1) mod N_REQ`. With no accept, `rr_ptr` holds.
- S1→S2: when `s2_adv`, S2 loads the S1 product (multiplier is combinational on S1), with `v2 <= v1`.
- S1 clears (`v1 <= 0`) when it advances and no new accept occurs.
- Results leave in accept order; none are dropped or duplicated.
- `busy = v1 || v2`.

## Timing
- Reset (async assert, sync-safe deassert): `v1 = v2 = 0`, `res_valid = 0`, `res_data = 0`, `res_id = 0`, `res_signed = 0`, `rr_ptr = 0`, `busy = 0`, `req_ready = 0` while `rst_n` is low.
- Latency: an accept at edge T gives `res_valid = 1` with the product from edge T+1 (one cycle after S1 loads).
- Throughput: one result per clock while `res_ready = 1` and any requester is valid.
- Backpressure: if `res_valid && !res_ready`, S2 holds. S1 holds too if full. Max 2 in flight, after which all `req_ready = 0`. `res_*` stay stable until the handshake completes.
- Simultaneous S2 drain and new accept: S1→S2 and accept into S1 happen on the same edge, so the pipeline keeps moving with no bubble.
- Reset mid-operation discards both stages immediately. No result is emitted for in-flight requests, and `rr_ptr` returns to 0.

## Test plan
- Signedness (N=8): req0 a=8'hFD, b=8'h05, signed=1 → `res_data` = 16'hFFF1, `res_id` = 0, 2 cycles after accept. The same operands with signed=0 → 16'h04F1.
- Extremes: a=b=8'hFF with signed=1 → 16'h0001; with signed=0 → 16'hFE01. a=b=8'h80 with signed=1 → 16'h4000, and 16'h4000 unsigned.
- Fairness: all four `req_valid` held high, `res_ready=1`, distinct operands → accepts in order 0,1,2,3,0,1…, one per clock. `res_id` follows the same sequence 2 cycles later, with every product correct.
- Backpressure: stream from req1, drop `res_ready` for 5 cycles → after 2 in flight, `req_ready` is all 0 and `res_data`/`res_id` stay stable. On release, results drain in order with no loss and no duplicates.
- Pointer wrap/skip: only req3 and req1 valid, `rr_ptr=0` → req1 granted, then req3, then req1. A lone req2 is accepted every cycle.
- Reset mid-stream: assert `rst_n=0` with both stages full → `res_valid`, `busy` and `req_ready` drop to 0 immediately. After release, the first grant goes to the lowest valid index from 0.
